// File: rtl/taus_pkg.sv
// Shared constants, seed helpers and FSM state type for the taus88 generator bank.
package taus_pkg;

    localparam int unsigned SEED_W = 96;

    localparam logic [31:0] DEF_S0 = 32'h0000_1234;
    localparam logic [31:0] DEF_S1 = 32'h0000_5678;
    localparam logic [31:0] DEF_S2 = 32'h0009_ABCD;

    // Smallest seed words that keep each taus88 component out of its all-zero trap.
    localparam logic [31:0] MIN_S0 = 32'd2;
    localparam logic [31:0] MIN_S1 = 32'd8;
    localparam logic [31:0] MIN_S2 = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    function automatic logic [31:0] seed_floor(input logic [31:0] v, input logic [31:0] m);
        return (v < m) ? m : v;
    endfunction

endpackage

// File: rtl/taus88_core.sv
// One taus88 generator: three state words, seed load, step enable, next-word output.
// With TAUS_SEED_FIX_EN defined, loaded seed words are raised to their minimums.
module taus88_core
    import taus_pkg::*;
#(
    parameter logic [31:0] INIT_OFS = 32'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [SEED_W-1:0] seed,
    input  logic              step,
    output logic [31:0]       word_nxt
);

    logic [31:0] s0, s1, s2;
    logic [31:0] n0, n1, n2;
    logic [31:0] l0, l1, l2;

    assign n0 = ((s0 & 32'hFFFF_FFFE) << 12) ^ (((s0 << 13) ^ s0) >> 19);
    assign n1 = ((s1 & 32'hFFFF_FFF8) << 4)  ^ (((s1 << 2)  ^ s1) >> 25);
    assign n2 = ((s2 & 32'hFFFF_FFF0) << 17) ^ (((s2 << 3)  ^ s2) >> 11);

    // The word is taken from the state the step is about to commit.
    assign word_nxt = n0 ^ n1 ^ n2;

`ifdef TAUS_SEED_FIX_EN
    assign l0 = seed_floor(seed[95:64], MIN_S0);
    assign l1 = seed_floor(seed[63:32], MIN_S1);
    assign l2 = seed_floor(seed[31:0],  MIN_S2);
`else
    assign l0 = seed[95:64];
    assign l1 = seed[63:32];
    assign l2 = seed[31:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0 <= DEF_S0 + INIT_OFS;
            s1 <= DEF_S1 + INIT_OFS;
            s2 <= DEF_S2 + INIT_OFS;
        end else if (load) begin
            s0 <= l0;
            s1 <= l1;
            s2 <= l2;
        end else if (step) begin
            s0 <= n0;
            s1 <= n1;
            s2 <= n2;
        end
    end

endmodule

// File: rtl/taus_urng_bank.sv
// Bank of N_GEN taus88 generators with warm-up, packed output word and valid/ready output.
// Optional build macro: TAUS_SEED_FIX_EN (clamps degenerate seeds inside taus88_core).
module taus_urng_bank
    import taus_pkg::*;
#(
    parameter int N_GEN  = 2,
    parameter int WARMUP = 8,
    parameter int U0_W   = 48,
    localparam int P_W   = 32 * N_GEN,
    localparam int IDX_W = (N_GEN > 1) ? $clog2(N_GEN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_we,
    input  logic [IDX_W-1:0]  seed_idx,
    input  logic [SEED_W-1:0] seed_data,
    input  logic              start,
    input  logic              stop,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [U0_W-1:0]   u0,
    output logic [P_W-U0_W-1:0] u1,
    output logic              busy
);

    localparam logic [7:0] WARMUP_LAST = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

    state_t         state;
    logic [7:0]     warm_cnt;
    logic [P_W-1:0] packed_nxt;
    logic           step_en;
    logic           seed_ok;

    // Handshake: a word transfers on an edge where out_valid && out_ready; while
    // out_valid && !out_ready the word, out_valid and all generator states hold.
    assign step_en = !stop && ((state == ST_WARMUP) ||
                               (state == ST_RUN && (!out_valid || out_ready)));
    assign seed_ok = seed_we && (state == ST_IDLE);
    assign busy    = (state != ST_IDLE);

    for (genvar k = 0; k < N_GEN; k++) begin : g_gen
        taus88_core #(.INIT_OFS(32'(k))) u_core (
            .clk      (clk),
            .reset    (reset),
            .load     (seed_ok && (int'(seed_idx) == k)),
            .seed     (seed_data),
            .step     (step_en),
            .word_nxt (packed_nxt[P_W-1-32*k -: 32])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            warm_cnt  <= 8'd0;
            out_valid <= 1'b0;
            u0        <= '0;
            u1        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        warm_cnt <= 8'd0;
                        state    <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                    end
                end
                ST_WARMUP: begin
                    if (stop) begin
                        state    <= ST_IDLE;
                        warm_cnt <= 8'd0;
                    end else if (warm_cnt == WARMUP_LAST) begin
                        state    <= ST_RUN;
                        warm_cnt <= 8'd0;
                    end else begin
                        warm_cnt <= warm_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end else if (!out_valid || out_ready) begin
                        u0        <= packed_nxt[P_W-1 -: U0_W];
                        u1        <= packed_nxt[P_W-U0_W-1:0];
                        out_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_taus_urng_bank.sv
// Randomized bench for taus_urng_bank against a word-level taus88 reference model.
module tb_taus_urng_bank;

    localparam int N_GEN  = 2;
    localparam int WARMUP = 8;
    localparam int U0_W   = 48;
    localparam int P_W    = 32 * N_GEN;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           seed_we = 1'b0;
    logic [0:0]     seed_idx = 1'b0;
    logic [95:0]    seed_data = '0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic           out_ready = 1'b0;

    logic              out_valid, busy;
    logic [U0_W-1:0]   u0;
    logic [P_W-U0_W-1:0] u1;
    logic              out_valid_z, busy_z;
    logic [U0_W-1:0]   u0_z;
    logic [P_W-U0_W-1:0] u1_z;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_s0 [N_GEN];
    logic [31:0] m_s1 [N_GEN];
    logic [31:0] m_s2 [N_GEN];
    logic [P_W-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    taus_urng_bank #(.N_GEN(N_GEN), .WARMUP(WARMUP), .U0_W(U0_W)) dut (
        .clk(clk), .reset(reset), .seed_we(seed_we), .seed_idx(seed_idx),
        .seed_data(seed_data), .start(start), .stop(stop), .out_ready(out_ready),
        .out_valid(out_valid), .u0(u0), .u1(u1), .busy(busy)
    );

    taus_urng_bank #(.N_GEN(N_GEN), .WARMUP(0), .U0_W(U0_W)) dut_z (
        .clk(clk), .reset(reset), .seed_we(seed_we), .seed_idx(seed_idx),
        .seed_data(seed_data), .start(start), .stop(stop), .out_ready(out_ready),
        .out_valid(out_valid_z), .u0(u0_z), .u1(u1_z), .busy(busy_z)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model
    task automatic model_reset();
        for (int k = 0; k < N_GEN; k++) begin
            m_s0[k] = 32'h0000_1234 + k;
            m_s1[k] = 32'h0000_5678 + k;
            m_s2[k] = 32'h0009_ABCD + k;
        end
    endtask

    task automatic model_seed(input int k, input logic [95:0] d);
        logic [31:0] a, b, c;
        a = d[95:64]; b = d[63:32]; c = d[31:0];
`ifdef TAUS_SEED_FIX_EN
        if (a < 2)  a = 2;
        if (b < 8)  b = 8;
        if (c < 16) c = 16;
`endif
        m_s0[k] = a; m_s1[k] = b; m_s2[k] = c;
    endtask

    task automatic model_advance(output logic [P_W-1:0] w);
        logic [31:0] a, b, c;
        w = '0;
        for (int k = 0; k < N_GEN; k++) begin
            a = m_s0[k]; b = m_s1[k]; c = m_s2[k];
            a = ((a & ~32'd1)  << 12) ^ (((a << 13) ^ a) >> 19);
            b = ((b & ~32'd7)  << 4)  ^ (((b << 2)  ^ b) >> 25);
            c = ((c & ~32'd15) << 17) ^ (((c << 3)  ^ c) >> 11);
            m_s0[k] = a; m_s1[k] = b; m_s2[k] = c;
            w = (w << 32) | P_W'(a ^ b ^ c);
        end
    endtask

    // driver tasks
    task automatic seed_write(input int k, input logic [95:0] d);
        @(negedge clk);
        seed_we = 1'b1; seed_idx = 1'(k); seed_data = d;
        model_seed(k, d);
        @(negedge clk);
        seed_we = 1'b0;
    endtask

    // chk0: 1 = first-word check on the zero-warm-up instance, 2 = its w[0] only
    task automatic start_and_wait(input int chk0, input logic with_seed, input logic [95:0] sd,
                                  input logic [31:0] exp_w0);
        logic [P_W-1:0] w;
        int cnt;
        logic got;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b1;
        if (with_seed) begin
            seed_we = 1'b1; seed_idx = 1'b0; seed_data = sd;
            model_seed(0, sd);
        end
        @(negedge clk);
        start = 1'b0; seed_we = 1'b0;
        cnt = 0; got = 1'b0;
        while (!got && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1 && chk0 == 1) begin
                check("z_valid", 64'(out_valid_z), 64'd1);
                check("z_u0", 64'(u0_z), 64'h0000_0020_2080_0020);
                check("z_u1", 64'(u1_z), 64'h2080);
            end
            if (cnt == 1 && chk0 == 2)
                check("z_w0", 64'(u0_z[47:16]), 64'(exp_w0));
            if (out_valid) got = 1'b1;
        end
        check("latency", 64'(cnt), 64'(WARMUP + 1));
        exp_q.delete();
        for (int i = 0; i < WARMUP; i++) model_advance(w);
        model_advance(w);
        exp_q.push_back(w);
        check("first_word", {u0, u1}, exp_q[0]);
    endtask

    // mode 0: random ready, 1: ready held high, 2: ready held low
    task automatic run_cycles(input int n, input int mode);
        logic [P_W-1:0] w;
        logic r;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("valid", 64'(out_valid), 64'd1);
            if (exp_q.size() == 0) begin
                model_advance(w);
                exp_q.push_back(w);
            end
            check("word", {u0, u1}, exp_q[0]);
            r = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            out_ready = r;
            start     = ($urandom_range(0, 7) == 0);
            seed_we   = ($urandom_range(0, 7) == 0);
            seed_idx  = 1'($urandom_range(0, 1));
            seed_data = {$urandom, $urandom, $urandom};
            if (r) void'(exp_q.pop_front());
        end
    endtask

    task automatic do_stop(input logic with_write, input logic [95:0] d);
        start = 1'b0;
        stop = 1'b1;
        seed_we = with_write; seed_idx = 1'b1; seed_data = d;
        @(negedge clk);
        stop = 1'b0; seed_we = 1'b0;
        check("stop_busy", 64'(busy), 64'd0);
        check("stop_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
    endtask

    task automatic reset_mid_run();
        #2;
        reset = 1'b0; start = 1'b0; seed_we = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_u0", 64'(u0), 64'd0);
        check("rst_u1", 64'(u1), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        exp_q.delete();
    endtask

    initial begin : main
        logic [95:0] sd;
        model_reset();
        repeat (3) @(negedge clk);
        check("init_valid", 64'(out_valid), 64'd0);
        check("init_u0", 64'(u0), 64'd0);
        check("init_u1", 64'(u1), 64'd0);
        check("init_busy", 64'(busy), 64'd0);
        reset = 1'b1;

        // minimal seeds on both generators, zero-warm-up instance checked too
        seed_write(0, {32'd2, 32'd8, 32'd16});
        seed_write(1, {32'd2, 32'd8, 32'd16});
        start_and_wait(1, 1'b0, '0, '0);
        run_cycles(10, 1);
        run_cycles(5, 2);
        run_cycles(40, 0);

        // zero seed, state of generator 1 carries over the stop
        do_stop(1'b0, '0);
        seed_write(0, '0);
`ifdef TAUS_SEED_FIX_EN
        start_and_wait(2, 1'b0, '0, 32'h0020_2080);
`else
        start_and_wait(2, 1'b0, '0, 32'h0000_0000);
`endif
        run_cycles(30, 0);

        // reset in the middle of a run, then the default-seed sequence
        reset_mid_run();
        start_and_wait(0, 1'b0, '0, '0);
        run_cycles(20, 0);

        // stop with a simultaneous seed write: write must be dropped
        do_stop(1'b1, {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D});
        start_and_wait(0, 1'b0, '0, '0);
        run_cycles(20, 0);

        // seed write in IDLE takes effect
        do_stop(1'b0, '0);
        sd = {$urandom | 32'h100, $urandom | 32'h100, $urandom | 32'h100};
        seed_write(1, sd);
        start_and_wait(0, 1'b0, '0, '0);
        run_cycles(20, 0);

        // seed write and start in the same cycle: warm-up uses the new seed
        do_stop(1'b0, '0);
        sd = {$urandom | 32'h100, $urandom | 32'h100, $urandom | 32'h100};
        start_and_wait(0, 1'b1, sd, '0);
        run_cycles(30, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/taus_urng_bank.md
TAUS_URNG_BANK -- requirements
Module: taus_urng_bank

Interface
REQ-001 SHALL have parameter N_GEN, default 2: number of Tausworthe (taus88) generators, 1..16.
REQ-002 SHALL have parameter WARMUP, default 8: number of discarded steps after start, 0..255.
REQ-003 SHALL have parameter U0_W, default 48: width of u0, where 0 < U0_W < 32*N_GEN.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port seed_we, input, 1 bit: seed write strobe.
REQ-007 SHALL have port seed_idx, input, max(1,$clog2(N_GEN)) bits: generator selected for the seed write.
REQ-008 SHALL have port seed_data, input, 96 bits: {s0,s1,s2}, with s0 in the MSBs.
REQ-009 SHALL have port start, input, 1 bit: begin warm-up and run.
REQ-010 SHALL have port stop, input, 1 bit: return to IDLE.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the output word.
REQ-012 SHALL have port out_valid, output, 1 bit: u0/u1 hold a valid word.
REQ-013 SHALL have port u0, output, U0_W bits: upper slice of the packed random word.
REQ-014 SHALL have port u1, output, 32*N_GEN-U0_W bits: lower slice of the packed random word.
REQ-015 SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-016 SHALL implement an FSM with states IDLE, WARMUP and RUN.
REQ-017 SHALL transition IDLE->WARMUP on start; if WARMUP==0, IDLE->RUN on start instead.
REQ-018 In WARMUP, SHALL step every generator once per cycle and count the steps; after WARMUP steps it SHALL move to RUN, with out_valid remaining 0 throughout WARMUP.
REQ-019 On each taus88 step, SHALL update s0=((s0&~1)<<12)^(((s0<<13)^s0)>>19), s1=((s1&~7)<<4)^(((s1<<2)^s1)>>25), s2=((s2&~15)<<17)^(((s2<<3)^s2)>>11); the word is s0^s1^s2 of the updated state, computed modulo 2^32.
REQ-020 SHALL pack the output as {w[0],w[1],...,w[N_GEN-1]}, with w[0] in the MSBs; u0 SHALL be the top U0_W bits and u1 the remainder.
REQ-021 In RUN, when out_valid==0 or (out_valid && out_ready), SHALL step all generators, load the packed word into the output register and set out_valid=1 in the same edge.
REQ-022 When out_valid && !out_ready, SHALL hold u0, u1 and out_valid stable and SHALL NOT step the generators.
REQ-023 out_valid SHALL first rise exactly WARMUP+1 rising edges after the edge that samples start.
REQ-024 stop in WARMUP or RUN SHALL move the FSM to IDLE at the next edge and clear out_valid; stop SHALL take priority over start and over an accept in the same cycle.
REQ-025 seed_we in IDLE SHALL write seed_data into generator seed_idx at the next edge; in WARMUP/RUN it SHALL be ignored; an seed_idx >= N_GEN SHALL be ignored.
REQ-026 seed_we and start asserted together in IDLE SHALL perform the write first; warm-up SHALL then use the new seed.
REQ-027 Generator state SHALL persist across stop; a subsequent start SHALL continue the sequence after a fresh warm-up.
REQ-028 start in WARMUP or RUN SHALL be ignored.

Reset
REQ-029 reset low SHALL immediately force state=IDLE, out_valid=0, u0=0, u1=0, busy=0 and warm-up count=0.
REQ-030 reset SHALL load generator k with DEF_S0+k, DEF_S1+k and DEF_S2+k.
REQ-031 reset deassertion SHALL be taken synchronously to clk; a reset mid-RUN SHALL discard the pending word.

Configuration
REQ-032 With TAUS_SEED_FIX_EN defined, each written seed word below its minimum SHALL be replaced by that minimum (s0<2 ->2, s1<8 ->8, s2<16 ->16).
REQ-033 Without TAUS_SEED_FIX_EN, seeds SHALL be stored unmodified; degenerate seeds give a stuck generator.

Structure
REQ-034 Package taus_pkg SHALL hold DEF_S0=32'h0000_1234, DEF_S1=32'h0000_5678, DEF_S2=32'h0009_ABCD, the minimum-seed constants, the FSM state enum and the seed-word width.
REQ-035 Sub-module taus88_core SHALL hold one generator's three state registers, load port, step enable and 32-bit word output; the top level SHALL instantiate N_GEN copies through a generate loop.

Verification
REQ-036 Test 1: with N_GEN=2, WARMUP=0, U0_W=48, both generators seeded {2,8,16} and start pulsed, the bench SHALL see out_valid 1 edge later with u0=48'h00202080_0020 and u1=16'h2080.
REQ-037 Test 2: with WARMUP=8 and out_ready=1, out_valid SHALL first rise 9 edges after start, and the words SHALL match a C taus88 model skipping 8 steps, with a new word every cycle.
REQ-038 Test 3: with out_ready held 0 for 5 cycles mid-RUN, u0/u1 SHALL stay constant; after release, the next word SHALL equal the model's next value with no skip.
REQ-039 Test 4: a zero seed written with TAUS_SEED_FIX_EN SHALL give a first word of 0x00202080; without the macro, w=0 forever.
REQ-040 Test 5: reset asserted mid-RUN SHALL drop out_valid to 0 with no clock edge, and after restart the output SHALL match the default-seed sequence.
REQ-041 Test 6: stop and seed_we asserted together in RUN SHALL take the FSM to IDLE with the write ignored; a later seed_we in IDLE SHALL take effect.
